// File: rtl/chart_store_if.sv
// rtl/chart_store_if.sv - chart-read bus between chart_store, the pages and the chart ROM
interface chart_store_if #(
    parameter int NAME_LEN  = 12,
    parameter int MAX_NOTES = 64,
    parameter int ADDR_W    = 11
);
    logic [7:0]        read_chart_id;
    logic [7:0]        name [NAME_LEN];
    logic [7:0]        note_cnt;
    logic [7:0]        note_key [MAX_NOTES];
    logic [7:0]        note_dur [MAX_NOTES];
    logic              chart_ready;
    logic              body_valid;
    logic [ADDR_W-1:0] rom_addr;
    logic [7:0]        rom_data;

    modport master (
        output read_chart_id, rom_data,
        input  name, note_cnt, note_key, note_dur, chart_ready, body_valid, rom_addr
    );

    modport slave (
        input  read_chart_id, rom_data,
        output name, note_cnt, note_key, note_dur, chart_ready, body_valid, rom_addr
    );
endinterface

// File: rtl/chart_store.sv
// rtl/chart_store.sv - chart header cache filled at boot plus on-demand note body loader
module chart_store #(
    parameter int NUM_CHARTS   = 7,
    parameter int NAME_LEN     = 12,
    parameter int MAX_NOTES    = 64,
    parameter int CHART_STRIDE = 256,
    parameter int ADDR_W       = 11
) (
    input  logic          prog_clk,
    input  logic          rst,
    chart_store_if.slave  bus
);
    localparam int IW = $clog2(NUM_CHARTS);
    localparam int BW = $clog2(NAME_LEN);
    localparam int NW = $clog2(MAX_NOTES);
    localparam int CW = NW + 2;
    localparam logic [7:0] SPACE = 8'h20;

    typedef enum logic [2:0] {BOOT, IDLE, LD_CNT, LD_BODY, LD_DONE} state_t;

    state_t          state;
    logic [7:0]      id_q;
    logic [7:0]      tgt_id;
    logic            tgt_vld;
    logic [IW-1:0]   bi_id;
    logic [BW-1:0]   bi_byte;
    logic            iss_done;
    logic            cap_vld;
    logic [IW-1:0]   cap_id;
    logic [BW-1:0]   cap_byte;
    logic            boot_last;
    logic [CW-1:0]   iss_j;
    logic [CW-1:0]   cap_j;
    logic [CW-1:0]   nbytes;
    logic [7:0]      cache [NUM_CHARTS][NAME_LEN];

    logic            id_valid;
    logic            changed;
    logic [7:0]      n_val;
    logic [8:0]      n_x2;

    function automatic logic [ADDR_W-1:0] base_of(input logic [7:0] id);
        logic [31:0] p;
        p = 32'(id) * 32'(CHART_STRIDE);
        return p[ADDR_W-1:0];
    endfunction

    always_comb begin
        id_valid = (id_q != 8'd0) && (id_q < 8'(NUM_CHARTS));
        // tgt_vld low forces a load right after boot even when id_q matches
        changed  = !tgt_vld || (id_q != tgt_id);
        n_val    = (bus.rom_data > 8'(MAX_NOTES)) ? 8'(MAX_NOTES) : bus.rom_data;
        n_x2     = {n_val, 1'b0};
    end

    always_ff @(posedge prog_clk) begin
        if (rst) begin
            state           <= BOOT;
            id_q            <= '0;
            tgt_id          <= '0;
            tgt_vld         <= 1'b0;
            bi_id           <= IW'(1);
            bi_byte         <= '0;
            iss_done        <= 1'b0;
            cap_vld         <= 1'b0;
            cap_id          <= '0;
            cap_byte        <= '0;
            boot_last       <= 1'b0;
            iss_j           <= '0;
            cap_j           <= '0;
            nbytes          <= '0;
            bus.chart_ready <= 1'b0;
            bus.body_valid  <= 1'b0;
            bus.rom_addr    <= '0;
            bus.note_cnt    <= '0;
            for (int b = 0; b < NAME_LEN; b++) bus.name[b] <= SPACE;
            for (int n = 0; n < MAX_NOTES; n++) begin
                bus.note_key[n] <= '0;
                bus.note_dur[n] <= '0;
            end
        end else begin
            id_q <= bus.read_chart_id;
            if (state != BOOT) begin
                for (int b = 0; b < NAME_LEN; b++)
                    bus.name[b] <= id_valid ? cache[id_q[IW-1:0]][b] : SPACE;
            end

            if (state == BOOT) begin
                // issue and capture run one cycle apart over the name bytes of ids 1..N-1
                if (!iss_done) begin
                    bus.rom_addr <= base_of(8'(bi_id)) + ADDR_W'(bi_byte);
                    cap_vld      <= 1'b1;
                    cap_id       <= bi_id;
                    cap_byte     <= bi_byte;
                    if (bi_byte == BW'(NAME_LEN - 1)) begin
                        bi_byte <= '0;
                        if (bi_id == IW'(NUM_CHARTS - 1)) iss_done <= 1'b1;
                        else                              bi_id    <= bi_id + IW'(1);
                    end else begin
                        bi_byte <= bi_byte + BW'(1);
                    end
                end else begin
                    cap_vld <= 1'b0;
                end
                if (cap_vld) begin
                    cache[cap_id][cap_byte] <= bus.rom_data;
                    if (cap_id == IW'(NUM_CHARTS - 1) && cap_byte == BW'(NAME_LEN - 1))
                        boot_last <= 1'b1;
                end
                if (boot_last) begin
                    bus.chart_ready <= 1'b1;
                    state           <= IDLE;
                end
            end else if (changed) begin
                tgt_id       <= id_q;
                tgt_vld      <= 1'b1;
                bus.note_cnt <= '0;
                iss_j        <= '0;
                cap_j        <= '0;
                for (int n = 0; n < MAX_NOTES; n++) begin
                    bus.note_key[n] <= '0;
                    bus.note_dur[n] <= '0;
                end
                if (id_valid) begin
                    bus.body_valid <= 1'b0;
                    bus.rom_addr   <= base_of(id_q) + ADDR_W'(NAME_LEN);
                    state          <= LD_CNT;
                end else begin
                    bus.body_valid <= 1'b1;
                    state          <= IDLE;
                end
            end else begin
                case (state)
                    LD_CNT: begin
                        bus.note_cnt <= n_val;
                        nbytes       <= n_x2[CW-1:0];
                        if (n_val == 8'd0) begin
                            state <= LD_DONE;
                        end else begin
                            bus.rom_addr <= base_of(tgt_id) + ADDR_W'(NAME_LEN + 1);
                            iss_j        <= CW'(1);
                            state        <= LD_BODY;
                        end
                    end
                    LD_BODY: begin
                        if (cap_j[0]) bus.note_dur[cap_j[NW:1]] <= bus.rom_data;
                        else          bus.note_key[cap_j[NW:1]] <= bus.rom_data;
                        if (iss_j != nbytes) begin
                            bus.rom_addr <= base_of(tgt_id) + ADDR_W'(NAME_LEN + 1) + ADDR_W'(iss_j);
                            iss_j        <= iss_j + CW'(1);
                        end
                        cap_j <= cap_j + CW'(1);
                        if (cap_j == nbytes - CW'(1)) state <= LD_DONE;
                    end
                    LD_DONE: begin
                        bus.body_valid <= 1'b1;
                        state          <= IDLE;
                    end
                    default: ;
                endcase
            end
        end
    end

    always @(posedge prog_clk) begin
        if (!rst && state == LD_BODY)
            assert (NAME_LEN + 1 + int'(iss_j) < CHART_STRIDE);
    end
endmodule

// File: tb/tb_chart_store.sv
// tb/tb_chart_store.sv - randomized self-checking bench for chart_store against a ROM-level model
module tb_chart_store;
    localparam int NUM_CHARTS = 7;
    localparam int NAME_LEN   = 12;
    localparam int MAX_NOTES  = 64;
    localparam int STRIDE     = 256;
    localparam int ADDR_W     = 11;

    logic prog_clk = 1'b0;
    logic rst;
    always #5 prog_clk = ~prog_clk;

    chart_store_if bus ();
    chart_store dut (.prog_clk(prog_clk), .rst(rst), .bus(bus));

    logic [7:0] mem [2**ADDR_W];
    assign bus.rom_data = mem[bus.rom_addr];

    int n_chk  = 0;
    int n_fail = 0;
    int max_off = 0;
    int cur;

    always @(negedge prog_clk)
        if (int'(bus.rom_addr) % STRIDE > max_off) max_off = int'(bus.rom_addr) % STRIDE;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge prog_clk);
    endtask

    function automatic logic [8*NAME_LEN-1:0] dut_name();
        logic [8*NAME_LEN-1:0] r;
        for (int b = 0; b < NAME_LEN; b++) r[8*(NAME_LEN-1-b) +: 8] = bus.name[b];
        return r;
    endfunction

    function automatic bit is_rom_id(input int id);
        return id >= 1 && id < NUM_CHARTS;
    endfunction

    function automatic logic [8*NAME_LEN-1:0] exp_name(input int id);
        logic [8*NAME_LEN-1:0] r;
        for (int b = 0; b < NAME_LEN; b++)
            r[8*(NAME_LEN-1-b) +: 8] = is_rom_id(id) ? mem[id*STRIDE + b] : 8'h20;
        return r;
    endfunction

    function automatic int exp_n(input int id);
        int c;
        if (!is_rom_id(id)) return 0;
        c = int'(mem[id*STRIDE + NAME_LEN]);
        return (c > MAX_NOTES) ? MAX_NOTES : c;
    endfunction

    // entered at the negedge following c0 of a load of `id`
    task automatic follow_load(input int id, input string tag, input logic [ADDR_W-1:0] a0);
        int first = -1;
        int n = exp_n(id);
        int t_exp = is_rom_id(id) ? 2*n + 3 : 1;
        int bad = 0;
        logic [7:0] ek, ed;
        for (int k = 1; k <= 400; k++) begin
            tick(1);
            if (k == 1) check({tag, ".name"}, dut_name(), exp_name(id));
            if (bus.body_valid) begin
                first = k;
                break;
            end
        end
        check({tag, ".bv_cycle"}, first, t_exp);
        check({tag, ".note_cnt"}, bus.note_cnt, n);
        for (int j = 0; j < MAX_NOTES; j++) begin
            ek = (j < n) ? mem[id*STRIDE + NAME_LEN + 1 + 2*j]     : 8'h00;
            ed = (j < n) ? mem[id*STRIDE + NAME_LEN + 1 + 2*j + 1] : 8'h00;
            if (bus.note_key[j] !== ek || bus.note_dur[j] !== ed) bad++;
        end
        check({tag, ".notes_bad"}, bad, 0);
        if (!is_rom_id(id)) check({tag, ".rom_addr_hold"}, bus.rom_addr, a0);
    endtask

    task automatic do_load(input int id, input string tag);
        bus.read_chart_id = 8'(id);
        tick(1);
        follow_load(id, tag, bus.rom_addr);
    endtask

    // entered at the negedge where rst has just been released
    task automatic boot_measure(input string tag);
        int first_iss = -1;
        int ready_at = -1;
        for (int k = 1; k <= 300; k++) begin
            tick(1);
            if (first_iss < 0 && bus.rom_addr == ADDR_W'(STRIDE)) first_iss = k;
            if (bus.chart_ready) begin
                ready_at = k;
                break;
            end
        end
        check({tag, ".ready_latency"}, ready_at - first_iss, (NUM_CHARTS - 1)*NAME_LEN + 1);
    endtask

    initial begin
        string nm [NUM_CHARTS] = '{"", "ALPHA", "BRAVO", "CHARL", "DELTA", "ECHO", "FOXTR"};
        int id;

        for (int i = 0; i < 2**ADDR_W; i++) mem[i] = 8'($urandom);
        for (int k = 1; k < NUM_CHARTS; k++)
            for (int b = 0; b < NAME_LEN; b++)
                mem[k*STRIDE + b] = (b < nm[k].len()) ? nm[k][b] : 8'h20;
        mem[1*STRIDE + NAME_LEN] = 8'($urandom_range(0, MAX_NOTES));
        mem[2*STRIDE + NAME_LEN] = 8'd40;
        mem[3*STRIDE + NAME_LEN] = 8'd5;
        mem[4*STRIDE + NAME_LEN] = 8'($urandom_range(1, 30));
        mem[5*STRIDE + NAME_LEN] = 8'd200;
        mem[6*STRIDE + NAME_LEN] = 8'd0;

        rst = 1'b1;
        bus.read_chart_id = 8'd0;
        tick(3);
        check("rst.ready",    bus.chart_ready, 0);
        check("rst.bv",       bus.body_valid, 0);
        check("rst.rom_addr", bus.rom_addr, 0);
        check("rst.note_cnt", bus.note_cnt, 0);
        check("rst.name",     dut_name(), exp_name(0));
        rst = 1'b0;
        boot_measure("boot1");
        tick(2);

        for (int k = 0; k < 10; k++) begin
            bus.read_chart_id = 8'(k);
            tick(2);
            check($sformatf("name%0d", k), dut_name(), exp_name(k));
        end

        bus.read_chart_id = 8'd0;
        tick(3);
        do_load(3, "t2");
        check("t2.key4", bus.note_key[4], mem[3*STRIDE + NAME_LEN + 1 + 8]);
        check("t2.dur4", bus.note_dur[4], mem[3*STRIDE + NAME_LEN + 1 + 9]);
        check("t2.key5", bus.note_key[5], 0);

        bus.read_chart_id = 8'd2;
        tick(1);
        tick(9);
        check("t3.bv_mid", bus.body_valid, 0);
        bus.read_chart_id = 8'd4;
        tick(1);
        follow_load(4, "t3", bus.rom_addr);

        max_off = 0;
        do_load(5, "t4");
        check("t4.max_off", max_off, NAME_LEN + 2*MAX_NOTES);

        bus.read_chart_id = 8'd1;
        tick(4);
        bus.read_chart_id = 8'd9;
        tick(1);
        check("t5.bv_c0", bus.body_valid, 0);
        follow_load(9, "t5", bus.rom_addr);
        cur = 9;

        repeat (8) begin
            id = int'($urandom_range(0, 9));
            if (id == cur) id = (id + 1) % 10;
            do_load(id, "rnd");
            cur = id;
        end

        bus.read_chart_id = (cur == 3) ? 8'd2 : 8'd3;
        tick(5);
        rst = 1'b1;
        tick(1);
        check("t6.ready", bus.chart_ready, 0);
        check("t6.bv",    bus.body_valid, 0);
        check("t6.name",  dut_name(), exp_name(0));
        tick(2);
        rst = 1'b0;
        boot_measure("boot2");
        tick(3);
        check("t6.name_after", dut_name(), exp_name(int'(bus.read_chart_id)));
        tick(150);
        check("t6.bv_after",  bus.body_valid, 1);
        check("t6.cnt_after", bus.note_cnt, exp_n(int'(bus.read_chart_id)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
